// File: rtl/pic_pkg.sv
// Shared definitions for the interrupt controller and its acknowledge sequencer.
// Holds the sequencer state encoding and the protocol constants of both CPU modes.
package pic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_DONE,
    ST_COOL
  } seq_state_t;

  localparam logic [7:0] CALL_OPCODE = 8'hCD;
  localparam logic [1:0] ACKS_8086   = 2'd2;
  localparam logic [1:0] ACKS_8080   = 2'd3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// It is reusable for the controller's IR inputs.
module sync_2ff (
  input  logic clk,
  input  logic reset_irr_bit,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset_irr_bit) begin
    if (reset_irr_bit) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/inta_sequencer.sv
// CPU-side interrupt-acknowledge initiator: issues the INTA_n pulse train for 8086/8080
// modes and captures the vector byte or the CALL address from the controller's data bus.
module inta_sequencer
  import pic_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        reset_irr_bit,
  input  logic        int_in,
  input  logic        enable,
  input  logic        mode_8086,
  input  logic [7:0]  data_in,
  output logic        inta_n,
  output logic [1:0]  ack_count,
  output logic        busy,
  output logic        vector_valid,
  output logic [7:0]  vector,
  output logic [15:0] call_addr,
  output logic        opcode_err
);

  localparam int MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(1);

  logic             int_s;
  seq_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       target, target_next;
  logic [1:0]       ack_next;
  logic             mode_q, mode_next;
  logic             pulse_end;
  logic             first_ok;

  sync_2ff u_int_sync (
    .clk           (clk),
    .reset_irr_bit (reset_irr_bit),
    .d             (int_in),
    .q             (int_s)
  );

  always_ff @(posedge clk or posedge reset_irr_bit) begin
    if (reset_irr_bit) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      target    <= ACKS_8086;
      mode_q    <= 1'b1;
      ack_count <= 2'd0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      target    <= target_next;
      mode_q    <= mode_next;
      ack_count <= ack_next;
    end
  end

  // Every timed state counts down to 1 and leaves on the edge after that.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    target_next = target;
    mode_next   = mode_q;
    ack_next    = ack_count;
    pulse_end   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (int_s && enable) begin
          mode_next   = mode_8086;
          target_next = mode_8086 ? ACKS_8086 : ACKS_8080;
          cnt_next    = PULSE_LOAD;
          state_next  = ST_LOW;
        end
      end
      ST_LOW: begin
        if (cnt == CNT_LAST) begin
          pulse_end = 1'b1;
          ack_next  = ack_count + 2'd1;
          if (ack_next < target) begin
            cnt_next   = GAP_LOAD;
            state_next = ST_HIGH;
          end else begin
            state_next = ST_DONE;
          end
        end else begin
          cnt_next = cnt - CNT_LAST;
        end
      end
      ST_HIGH: begin
        if (cnt == CNT_LAST) begin
          cnt_next   = PULSE_LOAD;
          state_next = ST_LOW;
        end else begin
          cnt_next = cnt - CNT_LAST;
        end
      end
      ST_DONE: begin
        cnt_next   = GAP_LOAD;
        state_next = ST_COOL;
      end
      ST_COOL: begin
        if (cnt == CNT_LAST) begin
          ack_next   = 2'd0;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt - CNT_LAST;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they change cleanly on the edge.
  always_ff @(posedge clk or posedge reset_irr_bit) begin
    if (reset_irr_bit) begin
      inta_n       <= 1'b1;
      busy         <= 1'b0;
      vector_valid <= 1'b0;
    end else begin
      inta_n       <= (state_next != ST_LOW);
      busy         <= (state_next != ST_IDLE);
      vector_valid <= (state_next == ST_DONE);
    end
  end

  // Bytes land on the edge that ends a pulse; only the active mode's fields change.
  always_ff @(posedge clk or posedge reset_irr_bit) begin
    if (reset_irr_bit) begin
      vector     <= 8'h00;
      call_addr  <= 16'h0000;
      opcode_err <= 1'b0;
      first_ok   <= 1'b1;
    end else if (pulse_end) begin
      if (mode_q) begin
        if (ack_count == 2'd1) vector <= data_in;
      end else begin
        case (ack_count)
          2'd0:    first_ok        <= (data_in == CALL_OPCODE);
          2'd1:    call_addr[7:0]  <= data_in;
          default: call_addr[15:8] <= data_in;
        endcase
        if (state_next == ST_DONE) opcode_err <= !first_ok;
      end
    end
  end

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: randomized acknowledge sequences compared cycle by cycle
// against a timeline computed from pulse/gap lengths and the captured-byte rules.
module tb_inta_sequencer;

  localparam int P = 4;
  localparam int G = 2;

  logic        clk = 1'b0;
  logic        reset_irr_bit;
  logic        int_in;
  logic        enable;
  logic        mode_8086;
  logic [7:0]  data_in;
  logic        inta_n;
  logic [1:0]  ack_count;
  logic        busy;
  logic        vector_valid;
  logic [7:0]  vector;
  logic [15:0] call_addr;
  logic        opcode_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  exp_vector;
  logic [15:0] exp_call;
  logic        exp_err;

  always #5 clk = ~clk;

  inta_sequencer #(
    .PULSE_CYCLES (P),
    .GAP_CYCLES   (G)
  ) dut (
    .clk           (clk),
    .reset_irr_bit (reset_irr_bit),
    .int_in        (int_in),
    .enable        (enable),
    .mode_8086     (mode_8086),
    .data_in       (data_in),
    .inta_n        (inta_n),
    .ack_count     (ack_count),
    .busy          (busy),
    .vector_valid  (vector_valid),
    .vector        (vector),
    .call_addr     (call_addr),
    .opcode_err    (opcode_err)
  );

  // Starts one sequence at the current negedge and follows it to IDLE.
  task automatic run_seq(input logic m, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input int exp_lat, input bit keep);
    logic [7:0] bytes [3];
    int n, d, last, lat, p, r;
    logic e_inta, e_busy, e_vv;
    logic [1:0] e_ack;
    bit last_low;
    bytes[0] = b0;
    bytes[1] = b1;
    bytes[2] = b2;
    n    = m ? 2 : 3;
    d    = n * P + (n - 1) * G;
    last = d + G + 1;
    if (m) exp_vector = b1;
    else begin
      exp_call = {b2, b1};
      exp_err  = (b0 != 8'hCD);
    end
    enable    = 1'b1;
    mode_8086 = m;
    int_in    = 1'b1;
    data_in   = 8'($urandom);
    lat = 0;
    while (lat < 12) begin
      @(negedge clk);
      lat++;
      if (inta_n === 1'b0) break;
    end
    n_cmp++;
    if (lat !== exp_lat || inta_n !== 1'b0) begin
      n_err++;
      $display("FAIL start_latency got %0d (inta_n=%b) exp %0d", lat, inta_n, exp_lat);
      return;
    end
    for (int k = 0; k <= last; k++) begin
      if (k > 0) @(negedge clk);
      last_low = 1'b0;
      p = 0;
      if (k < d) begin
        p = k / (P + G);
        r = k % (P + G);
        e_inta = (r >= P);
        e_ack  = 2'((r < P) ? p : p + 1);
        last_low = (r == P - 1);
        e_busy = 1'b1;
        e_vv   = 1'b0;
      end else if (k <= d + G) begin
        e_inta = 1'b1;
        e_ack  = 2'(n);
        e_busy = 1'b1;
        e_vv   = (k == d);
      end else begin
        e_inta = 1'b1;
        e_ack  = 2'd0;
        e_busy = 1'b0;
        e_vv   = 1'b0;
      end
      n_cmp++;
      if (inta_n !== e_inta) begin
        n_err++;
        $display("FAIL inta_n k=%0d got %b exp %b", k, inta_n, e_inta);
      end
      n_cmp++;
      if (ack_count !== e_ack) begin
        n_err++;
        $display("FAIL ack_count k=%0d got %0d exp %0d", k, ack_count, e_ack);
      end
      n_cmp++;
      if (busy !== e_busy) begin
        n_err++;
        $display("FAIL busy k=%0d got %b exp %b", k, busy, e_busy);
      end
      n_cmp++;
      if (vector_valid !== e_vv) begin
        n_err++;
        $display("FAIL vector_valid k=%0d got %b exp %b", k, vector_valid, e_vv);
      end
      if (k == d) begin
        n_cmp++;
        if (vector !== exp_vector) begin
          n_err++;
          $display("FAIL vector got %h exp %h", vector, exp_vector);
        end
        n_cmp++;
        if (call_addr !== exp_call) begin
          n_err++;
          $display("FAIL call_addr got %h exp %h", call_addr, exp_call);
        end
        n_cmp++;
        if (opcode_err !== exp_err) begin
          n_err++;
          $display("FAIL opcode_err got %b exp %b", opcode_err, exp_err);
        end
      end
      data_in = last_low ? bytes[p] : 8'($urandom);
      if (!keep && k == 0) int_in = 1'b0;
      if (!keep && k == 1) begin
        enable    = 1'($urandom_range(0, 1));
        mode_8086 = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic test_reset();
    reset_irr_bit = 1'b1;
    int_in = 1'b0;
    enable = 1'b0;
    mode_8086 = 1'b1;
    data_in = 8'h00;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({inta_n, busy, ack_count, vector_valid} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_ctrl got %b exp 10000", {inta_n, busy, ack_count, vector_valid});
    end
    n_cmp++;
    if ({vector, call_addr, opcode_err} !== 25'd0) begin
      n_err++;
      $display("FAIL reset_data got %h exp 0", {vector, call_addr, opcode_err});
    end
    reset_irr_bit = 1'b0;
    exp_vector = 8'h00;
    exp_call   = 16'h0000;
    exp_err    = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({inta_n, busy} !== 2'b10) begin
      n_err++;
      $display("FAIL post_reset_idle got %b exp 10", {inta_n, busy});
    end
  endtask

  task automatic test_8086();
    run_seq(1'b1, 8'($urandom), 8'h48, 8'($urandom), 3, 1'b0);
  endtask

  task automatic test_8080();
    run_seq(1'b0, 8'hCD, 8'h20, 8'h3F, 3, 1'b0);
  endtask

  task automatic test_bad_opcode();
    run_seq(1'b0, 8'hC3, 8'h11, 8'h22, 3, 1'b0);
  endtask

  task automatic test_gating();
    enable = 1'b0;
    int_in = 1'b1;
    mode_8086 = 1'b1;
    repeat (20) begin
      @(negedge clk);
      n_cmp++;
      if (inta_n !== 1'b1 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL gating got inta_n=%b busy=%b exp 1/0", inta_n, busy);
      end
    end
    run_seq(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1, 1'b0);
  endtask

  task automatic test_random();
    logic m;
    logic [7:0] b0;
    for (int i = 0; i < 8; i++) begin
      m  = 1'($urandom_range(0, 1));
      b0 = $urandom_range(0, 1) ? 8'hCD : 8'($urandom);
      run_seq(m, b0, 8'($urandom), 8'($urandom), 3, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    enable = 1'b1;
    mode_8086 = 1'($urandom_range(0, 1));
    int_in = 1'b1;
    w = 0;
    while (w < 12) begin
      @(negedge clk);
      w++;
      if (inta_n === 1'b0) break;
    end
    n_cmp++;
    if (inta_n !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_start got inta_n=%b exp 0", inta_n);
    end
    repeat (P + G + 1) @(negedge clk);
    n_cmp++;
    if (inta_n !== 1'b0 || ack_count !== 2'd1) begin
      n_err++;
      $display("FAIL pulse2_before_reset got inta_n=%b ack=%0d exp 0/1", inta_n, ack_count);
    end
    int_in = 1'b0;
    #2 reset_irr_bit = 1'b1;
    #1;
    n_cmp++;
    if ({inta_n, busy, ack_count, vector_valid} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_mid_async got %b exp 10000", {inta_n, busy, ack_count, vector_valid});
    end
    @(negedge clk);
    reset_irr_bit = 1'b0;
    exp_vector = 8'h00;
    exp_call   = 16'h0000;
    exp_err    = 1'b0;
    repeat (20) begin
      @(negedge clk);
      n_cmp++;
      if (vector_valid !== 1'b0 || inta_n !== 1'b1) begin
        n_err++;
        $display("FAIL reset_mid_quiet got vv=%b inta_n=%b exp 0/1", vector_valid, inta_n);
      end
    end
    n_cmp++;
    if ({vector, call_addr, opcode_err} !== 25'd0) begin
      n_err++;
      $display("FAIL reset_mid_data got %h exp 0", {vector, call_addr, opcode_err});
    end
  endtask

  // With int_in held, the restart follows GAP_CYCLES+1 cycles after vector_valid drops:
  // the first run ends on the IDLE sample, and the restart is seen one cycle later.
  task automatic test_back_to_back();
    run_seq(1'($urandom_range(0, 1)), 8'hCD, 8'($urandom), 8'($urandom), 3, 1'b1);
    run_seq(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom), 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_8086();
    test_8080();
    test_bad_opcode();
    test_gating();
    test_random();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inta_sequencer.md
# inta_sequencer

CPU-side initiator of the interrupt-acknowledge protocol for the programmable interrupt controller. It watches the controller's INT output, issues the INTA_n pulse train (two pulses in 8086 mode, three in 8080 mode) and captures the bytes the controller drives on the data bus. It then presents the resulting vector or CALL address to the CPU core. Its pulse count is the same quantity the controller tracks as number_of_ack. It is the counterpart that makes the controller clear its request bits.

## Interface
- PULSE_CYCLES, 4: clk cycles INTA_n is held low per pulse (min 2).
- GAP_CYCLES, 2: clk cycles INTA_n is held high between pulses and after the sequence (min 1).
- clk  in  1  system clock; all state changes on the rising edge.
- reset_irr_bit  in  1  reset, asynchronous, active-high.
- int_in  in  1  INT from the controller; asynchronous, passed through a 2-flop synchronizer.
- enable  in  1  CPU interrupt-enable flag; sampled only in IDLE.
- mode_8086  in  1  1: two-pulse sequence; 0: three-pulse 8080 sequence. Sampled at sequence start.
- data_in  in  8  controller data bus.
- inta_n  out  1  acknowledge strobe, active-low.
- ack_count  out  2  number of pulses completed in the current sequence.
- busy  out  1  high from the first INTA_n fall until return to IDLE.
- vector_valid  out  1  one-cycle pulse; result outputs are valid.
- vector  out  8  8086 vector byte.
- call_addr  out  16  8080 CALL target address, {high byte, low byte}.
- opcode_err  out  1  set with vector_valid when the 8080 first byte is not 8'hCD.

## Operation
- States: IDLE, LOW, HIGH, DONE, COOL.
- IDLE: if int_s & enable, latch mode_8086, set target = 2 (8086) or 3 (8080), load the counter, and go to LOW.
- LOW: inta_n = 0 for PULSE_CYCLES cycles. On the exiting edge:
  - capture data_in;
  - increment ack_count;
  - go to HIGH if ack_count+1 < target, else DONE.
- Capture mapping:
  - 8086: pulse 1 byte is discarded; pulse 2 byte goes to vector.
  - 8080: pulse 1 is checked against 8'hCD; pulse 2 goes to call_addr[7:0]; pulse 3 goes to call_addr[15:8].
- HIGH: inta_n = 1 for GAP_CYCLES cycles, then LOW.
- DONE: vector_valid = 1 for exactly one cycle, opcode_err updated, then COOL.
- COOL: GAP_CYCLES cycles. Clears ack_count to 0 and returns to IDLE. A still-high int_s then starts a new sequence immediately.
- Once started, a sequence always runs to completion, whether enable drops or int_in falls mid-sequence. The controller supplies the spurious vector in that case.
- vector, call_addr and opcode_err hold their last values until overwritten. Only the fields of the active mode are updated.
- Counters are sized for max(PULSE_CYCLES, GAP_CYCLES) and count down to 1.

## Timing
- Reset values:
  - inta_n = 1; busy = 0; ack_count = 0; vector_valid = 0; vector = 0; call_addr = 0; opcode_err = 0; state IDLE; synchronizer flops 0.
  - Reset forces inta_n high immediately (asynchronously), including mid-pulse. No partial result is flagged.
- int_in rising before edge 0 gives int_s = 1 after edge 1. inta_n falls on edge 2, if enable is high in IDLE at that edge.
- data_in is registered on the edge where inta_n returns high. It must be stable during the final LOW cycle.
- With defaults in 8086 mode:
  - inta_n low for edges 2–6, high for edges 6–8, low for edges 8–12;
  - vector_valid high for cycle 12–13;
  - idle again after edge 15.
- 8080 mode adds one extra HIGH plus one extra LOW period (6 more cycles).
- busy rises with the first inta_n fall and drops on entry to IDLE.

## Structure
- Shared package pic_pkg:
  - state enum for IDLE/LOW/HIGH/DONE/COOL;
  - CALL_OPCODE = 8'hCD;
  - ACKS_8086 = 2 and ACKS_8080 = 3.
- Sub-module sync_2ff (1-bit, async reset) for int_in. It is reusable for the controller's IR inputs.

## Test plan
- 8086 path: int_in = 1, enable = 1, mode_8086 = 1, data_in = 8'h48 on pulse 2 -> two 4-cycle low pulses; ack_count goes 1 then 2; vector = 8'h48; vector_valid for one cycle.
- 8080 path: mode_8086 = 0, bytes CD/20/3F -> three pulses; call_addr = 16'h3F20; opcode_err = 0.
- Bad opcode: 8080 mode with first byte 8'hC3 -> opcode_err = 1 together with vector_valid.
- Gating: enable = 0 while int_in = 1 for 20 cycles -> inta_n stays 1. Raising enable starts a sequence on the next edge.
- Mid-sequence events:
  - int_in falls during pulse 1 -> the sequence still completes with two pulses;
  - reset_irr_bit asserted mid-LOW -> inta_n = 1 at once, ack_count = 0, no vector_valid.
- Back-to-back: int_in held high across two sequences -> second sequence starts exactly GAP_CYCLES+1 cycles after vector_valid.
